instr_mem_loader: RTL and testbench

Writer side of the instruction memory: receives a program as a byte stream and writes it word-by-word into the instruction store. It sits between a boot byte source (UART/debug link) and the instruction memory write port. It holds the CPU in reset until the load completes. Words are byte-addressed on the same >>2 word indexing the instruction memory uses for reads.

---
 rtl/instr_mem_loader.sv | 147 ++++++++++++++
 tb/tb_instr_mem_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Boot loader: turns a length-prefixed little-endian byte stream into 32-bit instruction memory writes.
// Each word is written the cycle after its 4th byte; byte_ready drops for that cycle, and the CPU is held until the load finishes.
module instr_mem_loader #(
  parameter int DEPTH     = 1024,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 mem_we,
  output logic [31:0]          mem_address,
  output logic [31:0]          mem_wdata,
  output logic                 cpu_hold,
  output logic                 load_done,
  output logic                 load_error,
  output logic [CNT_WIDTH-1:0] words_loaded
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  state_t               state;
  state_t               state_nx;

  logic                 take;
  logic                 start_ok;
  logic                 hdr_idx;
  logic [1:0]           byte_idx;
  logic [7:0]           hdr_lo;
  logic [15:0]          hdr_n;
  logic [CNT_WIDTH-1:0] word_count;
  logic [CNT_WIDTH-1:0] wl_next;
  logic [23:0]          asm_word;

  assign take     = byte_valid & byte_ready;
  assign start_ok = start & ((state == IDLE) | (state == DONE) | (state == ERROR));
  assign hdr_n    = {byte_in, hdr_lo};
  assign wl_next  = words_loaded + CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    cpu_hold   = 1'b0;
    load_done  = 1'b0;
    load_error = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = HDR;
      end
      HDR: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (take && hdr_idx) begin
          if (hdr_n == 16'd0)
            state_nx = DONE;
          else if ({16'd0, hdr_n} > 32'(DEPTH))
            state_nx = ERROR;
          else
            state_nx = DATA;
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (take && (byte_idx == 2'd3)) state_nx = WRITE;
      end
      WRITE: begin
        mem_we   = 1'b1;
        cpu_hold = 1'b1;
        state_nx = (wl_next == word_count) ? DONE : DATA;
      end
      DONE: begin
        load_done = 1'b1;
        if (start) state_nx = HDR;
      end
      ERROR: begin
        load_error = 1'b1;
        if (start) state_nx = HDR;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Write address/data are captured on the 4th-byte edge so they hold steady
  // through WRITE and afterwards, while the assembly register refills.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_idx      <= 1'b0;
      byte_idx     <= 2'd0;
      hdr_lo       <= 8'd0;
      word_count   <= '0;
      asm_word     <= 24'd0;
      words_loaded <= '0;
      mem_address  <= 32'd0;
      mem_wdata    <= 32'd0;
    end else begin
      if (start_ok) begin
        hdr_idx      <= 1'b0;
        byte_idx     <= 2'd0;
        asm_word     <= 24'd0;
        words_loaded <= '0;
      end

      if ((state == HDR) && take) begin
        hdr_idx <= ~hdr_idx;
        if (!hdr_idx)
          hdr_lo <= byte_in;
        else
          word_count <= CNT_WIDTH'(hdr_n);
      end

      if ((state == DATA) && take) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0: asm_word[7:0]   <= byte_in;
          2'd1: asm_word[15:8]  <= byte_in;
          2'd2: asm_word[23:16] <= byte_in;
          default: begin
            mem_wdata   <= {byte_in, asm_word};
            mem_address <= 32'({words_loaded, 2'b00});
          end
        endcase
      end

      if (state == WRITE) words_loaded <= wl_next;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: normal load, zero/oversize headers, gaps, ignored start, reset mid-load.
module tb_instr_mem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_loaded;

  int n_tests = 0;
  int n_fail  = 0;
  int hold_viol = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  instr_mem_loader #(.DEPTH(1024), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && mem_we) begin
      wa.push_back(mem_address);
      wd.push_back(mem_wdata);
    end
    if (cpu_hold && (load_done || load_error)) hold_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called and returns at a negedge; returns at the negedge right after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 0;
    repeat (gap) @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (byte_ready) begin
        @(posedge clk);
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("byte accept timeout", 32'(byte_ready), 32'd1);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input string tag);
    send_byte(w[7:0], gap);
    send_byte(w[15:8], gap);
    send_byte(w[23:16], gap);
    check({tag, " we low before 4th"}, 32'(mem_we), 32'd0);
    send_byte(w[31:24], gap);
    check({tag, " we right after 4th"}, 32'(mem_we), 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (load_done || load_error) break;
      @(negedge clk);
    end
    check({tag, " end reached"}, 32'(load_done | load_error), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " we"},    32'(mem_we),       32'd0);
    check({tag, " addr"},  mem_address,       32'd0);
    check({tag, " wdata"}, mem_wdata,         32'd0);
    check({tag, " hold"},  32'(cpu_hold),     32'd0);
    check({tag, " done"},  32'(load_done),    32'd0);
    check({tag, " err"},   32'(load_error),   32'd0);
    check({tag, " wl"},    32'(words_loaded), 32'd0);
    check({tag, " rdy"},   32'(byte_ready),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    byte_in    = 8'd0;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // 1: normal two-word load
    wa.delete(); wd.delete();
    pulse_start();
    check("t1 hold in hdr", 32'(cpu_hold), 32'd1);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_word(32'hE3A00001, 0, "t1 w0");
    send_word(32'hE3A00014, 0, "t1 w1");
    wait_end("t1");
    check("t1 nwrites", 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      check("t1 addr0", wa[0], 32'd0);
      check("t1 data0", wd[0], 32'hE3A00001);
      check("t1 addr1", wa[1], 32'd4);
      check("t1 data1", wd[1], 32'hE3A00014);
    end
    check("t1 wl",    32'(words_loaded), 32'd2);
    check("t1 done",  32'(load_done),    32'd1);
    check("t1 err",   32'(load_error),   32'd0);
    check("t1 hold",  32'(cpu_hold),     32'd0);
    check("t1 addr held", mem_address,   32'd4);
    check("t1 data held", mem_wdata,     32'hE3A00014);

    // 2: zero word count
    wa.delete(); wd.delete();
    pulse_start();
    check("t2 done cleared", 32'(load_done), 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    wait_end("t2");
    check("t2 nwrites", 32'(wa.size()),    32'd0);
    check("t2 wl",      32'(words_loaded), 32'd0);
    check("t2 done",    32'(load_done),    32'd1);

    // 3: oversize header N=1025
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    wait_end("t3");
    check("t3 err",  32'(load_error), 32'd1);
    check("t3 done", 32'(load_done),  32'd0);
    check("t3 hold", 32'(cpu_hold),   32'd0);
    byte_in    = 8'h55;
    byte_valid = 1'b1;
    @(negedge clk);
    check("t3 rdy after err", 32'(byte_ready), 32'd0);
    byte_valid = 1'b0;
    check("t3 nwrites", 32'(wa.size()), 32'd0);

    // 4: same stream as 1 with 3-cycle gaps
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'h02, 3);
    send_byte(8'h00, 3);
    send_word(32'hE3A00001, 3, "t4 w0");
    send_word(32'hE3A00014, 3, "t4 w1");
    wait_end("t4");
    check("t4 nwrites", 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      check("t4 addr0", wa[0], 32'd0);
      check("t4 data0", wd[0], 32'hE3A00001);
      check("t4 addr1", wa[1], 32'd4);
      check("t4 data1", wd[1], 32'hE3A00014);
    end
    check("t4 done", 32'(load_done), 32'd1);

    // 5: start mid-DATA is ignored, restart from DONE
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    pulse_start();
    check("t5 still loading", 32'(cpu_hold),   32'd1);
    check("t5 still ready",   32'(byte_ready), 32'd1);
    send_byte(8'hA0, 0);
    send_byte(8'hE3, 0);
    send_word(32'hE3A00014, 0, "t5 w1");
    wait_end("t5");
    check("t5 nwrites", 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      check("t5 data0", wd[0], 32'hE3A00001);
      check("t5 addr1", wa[1], 32'd4);
    end
    check("t5 wl", 32'(words_loaded), 32'd2);
    wa.delete(); wd.delete();
    pulse_start();
    check("t5 restart done clr", 32'(load_done),    32'd0);
    check("t5 restart wl clr",   32'(words_loaded), 32'd0);
    check("t5 restart hold",     32'(cpu_hold),     32'd1);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(32'hDEADBEEF, 0, "t5 r0");
    wait_end("t5r");
    check("t5r nwrites", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      check("t5r addr0", wa[0], 32'd0);
      check("t5r data0", wd[0], 32'hDEADBEEF);
    end
    check("t5r done", 32'(load_done), 32'd1);

    // 6: reset after 5 data bytes, then a fresh one-word load
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_word(32'hE3A00001, 0, "t6 w0");
    send_byte(8'h77, 0);
    check("t6 hold before rst", 32'(cpu_hold), 32'd1);
    rst = 1'b0;
    #1;
    check_all_zero("t6 rst");
    @(negedge clk);
    rst = 1'b1;
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(32'h11223344, 0, "t6 n0");
    wait_end("t6");
    check("t6 nwrites", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      check("t6 addr0", wa[0], 32'd0);
      check("t6 data0", wd[0], 32'h11223344);
    end
    check("t6 wl",   32'(words_loaded), 32'd1);
    check("t6 done", 32'(load_done),    32'd1);

    check("hold overlaps flag", 32'(hold_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
